// File: rtl/frame_pkg.sv
// Shared definitions for the pulse-config frame: header default, frame length,
// byte positions and FSM state encoding. The receive decoder uses the same byte map.
package frame_pkg;

  localparam logic [7:0] FRAME_HDR_DEFAULT = 8'h07;
  localparam int         FRAME_LEN         = 9;
  localparam int         IDX_W             = 4;

  // Byte positions within the frame, MSB of each 16-bit field first
  localparam logic [IDX_W-1:0] IDX_HDR   = 4'd0;
  localparam logic [IDX_W-1:0] IDX_EN1   = 4'd1;
  localparam logic [IDX_W-1:0] IDX_EN2   = 4'd2;
  localparam logic [IDX_W-1:0] IDX_W1_H  = 4'd3;
  localparam logic [IDX_W-1:0] IDX_W1_L  = 4'd4;
  localparam logic [IDX_W-1:0] IDX_W2_H  = 4'd5;
  localparam logic [IDX_W-1:0] IDX_W2_L  = 4'd6;
  localparam logic [IDX_W-1:0] IDX_GAP_H = 4'd7;
  localparam logic [IDX_W-1:0] IDX_GAP_L = 4'd8;
  localparam logic [IDX_W-1:0] IDX_CSUM  = 4'd9;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SEND = 3'd2,
    WAIT = 3'd3,
    FIN  = 3'd4
  } frame_state_t;

  // One UART byte is 10 bit times plus one guard bit; the division truncates
  function automatic int byte_cycles(input int clk_freq, input int uart_bps);
    return (clk_freq / uart_bps) * 11;
  endfunction

endpackage

// File: rtl/pulse_cfg_frame_tx_byte_pacer.sv
// byte_pacer: down-counter that spaces consecutive bytes handed to uart_tx.
// load presets the count; while count_en is high it counts down and expire
// fires in the cycle the count reaches zero.
module byte_pacer #(
  parameter int CNT_W    = 8,
  parameter int LOAD_VAL = 110
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic load,
  input  logic count_en,
  output logic expire
);

  logic [CNT_W-1:0] cnt_q;

  // Expire on the last counted cycle; also on an empty count so a waiting FSM can never stall
  assign expire = count_en && (cnt_q <= CNT_W'(1));

  // Pacing counter: preset on load, decrement while enabled, stop at zero
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= CNT_W'(LOAD_VAL);
    end else if (count_en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pulse_cfg_frame_tx.sv
// pulse_cfg_frame_tx: serialises one pulse-configuration frame into bytes for
// uart_tx, one pi_flag strobe per byte, paced by byte_pacer.
// Optional build macro FRAME_CHECKSUM_EN appends an 8-bit sum byte (index 9).
module pulse_cfg_frame_tx
  import frame_pkg::*;
#(
  parameter int         UART_BPS  = 9600,
  parameter int         CLK_FREQ  = 50_000_000,
  parameter logic [7:0] FRAME_HDR = FRAME_HDR_DEFAULT
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        send_req,
  input  logic        en1,
  input  logic        en2,
  input  logic [15:0] pulse_width1,
  input  logic [15:0] pulse_width2,
  input  logic [15:0] pulse_gap,
  output logic [7:0]  pi_data,
  output logic        pi_flag,
  output logic        busy,
  output logic        done
);

  localparam int BYTE_CYCLES = byte_cycles(CLK_FREQ, UART_BPS);
  localparam int CNT_W       = $clog2(BYTE_CYCLES + 1);

`ifdef FRAME_CHECKSUM_EN
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_CSUM;
`else
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_GAP_L;
`endif

  frame_state_t     state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic             accept;
  logic             pacer_load;
  logic             pacer_run;
  logic             pacer_expire;
  logic [7:0]       byte_sel;

  logic             en1_q, en2_q;
  logic [15:0]      width1_q, width2_q, gap_q;

`ifdef FRAME_CHECKSUM_EN
  function automatic logic [7:0] csum8(input logic [7:0] hdr, input logic e1, input logic e2,
                                       input logic [15:0] w1, input logic [15:0] w2,
                                       input logic [15:0] g);
    logic [7:0] s;
    s = hdr + {7'd0, e1} + {7'd0, e2};
    s = s + w1[15:8] + w1[7:0] + w2[15:8] + w2[7:0] + g[15:8] + g[7:0];
    return s;
  endfunction
`endif

  byte_pacer #(
    .CNT_W    (CNT_W),
    .LOAD_VAL (BYTE_CYCLES)
  ) u_byte_pacer (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .load      (pacer_load),
    .count_en  (pacer_run),
    .expire    (pacer_expire)
  );

  // State register
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next-state and strobe decode; requests are only honoured in IDLE, so a
  // request during a frame (including FIN) is dropped rather than queued
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    pacer_load = 1'b0;
    pacer_run  = 1'b0;
    pi_flag    = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (send_req) begin
          accept  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: state_d = SEND;
      SEND: begin
        pi_flag    = 1'b1;
        pacer_load = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        pacer_run = 1'b1;
        if (pacer_expire) state_d = (idx_q == LAST_IDX) ? FIN : LOAD;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Shadow copy of the frame fields, frozen for the whole frame
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      en1_q    <= 1'b0;
      en2_q    <= 1'b0;
      width1_q <= '0;
      width2_q <= '0;
      gap_q    <= '0;
    end else if (accept) begin
      en1_q    <= en1;
      en2_q    <= en2;
      width1_q <= pulse_width1;
      width2_q <= pulse_width2;
      gap_q    <= pulse_gap;
    end
  end

  // Byte index: restart at each new frame, advance only below the last byte
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      idx_q <= '0;
    end else if (accept) begin
      idx_q <= '0;
    end else if ((state_q == WAIT) && pacer_expire && (idx_q != LAST_IDX)) begin
      idx_q <= idx_q + IDX_W'(1);
    end
  end

  // Byte mux over the shadow registers
  always_comb begin
    byte_sel = 8'h00;
    case (idx_q)
      IDX_HDR:   byte_sel = FRAME_HDR;
      IDX_EN1:   byte_sel = {7'd0, en1_q};
      IDX_EN2:   byte_sel = {7'd0, en2_q};
      IDX_W1_H:  byte_sel = width1_q[15:8];
      IDX_W1_L:  byte_sel = width1_q[7:0];
      IDX_W2_H:  byte_sel = width2_q[15:8];
      IDX_W2_L:  byte_sel = width2_q[7:0];
      IDX_GAP_H: byte_sel = gap_q[15:8];
      IDX_GAP_L: byte_sel = gap_q[7:0];
`ifdef FRAME_CHECKSUM_EN
      IDX_CSUM:  byte_sel = csum8(FRAME_HDR, en1_q, en2_q, width1_q, width2_q, gap_q);
`endif
      default:   byte_sel = 8'h00;
    endcase
  end

  // Output byte register: updated in LOAD, held between strobes
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n)            pi_data <= 8'h00;
    else if (state_q == LOAD)  pi_data <= byte_sel;
  end

endmodule

// File: tb/tb_pulse_cfg_frame_tx.sv
// Scoreboard bench for pulse_cfg_frame_tx with CLK_FREQ=1000, UART_BPS=100.
module tb_pulse_cfg_frame_tx;

  localparam int B    = 110;
  localparam int STEP = B + 2;
`ifdef FRAME_CHECKSUM_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif

  logic        sys_clk;
  logic        sys_rst_n;
  logic        send_req;
  logic        en1, en2;
  logic [15:0] pulse_width1, pulse_width2, pulse_gap;
  logic [7:0]  pi_data;
  logic        pi_flag, busy, done;

  pulse_cfg_frame_tx #(
    .UART_BPS  (100),
    .CLK_FREQ  (1000),
    .FRAME_HDR (8'h07)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .send_req     (send_req),
    .en1          (en1),
    .en2          (en2),
    .pulse_width1 (pulse_width1),
    .pulse_width2 (pulse_width2),
    .pulse_gap    (pulse_gap),
    .pi_data      (pi_data),
    .pi_flag      (pi_flag),
    .busy         (busy),
    .done         (done)
  );

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         done_q[$];
  int         cyc = 0;
  int         busy_lo = 1;
  int         busy_hi = 0;
  int         clear_cyc = -1;
  logic [7:0] model_last = 8'h00;
  int         total = 0;
  int         bad = 0;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at cycle %0d", name, act, want, cyc);
    end
  endtask

  // Monitor: every cycle compare strobe, byte, done and busy against the scoreboard
  always @(negedge sys_clk) begin
    if (cyc == clear_cyc) model_last = 8'h00;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      chk("strobe_present", {31'd0, pi_flag}, 32'd1);
      if (pi_flag === 1'b1) chk("byte", {24'd0, pi_data}, {24'd0, exp_q[0].data});
      model_last = exp_q[0].data;
      void'(exp_q.pop_front());
    end else begin
      chk("no_strobe", {31'd0, pi_flag}, 32'd0);
    end
    chk("pi_data_hold", {24'd0, pi_data}, {24'd0, model_last});
    if (done_q.size() > 0 && done_q[0] == cyc) begin
      chk("done_present", {31'd0, done}, 32'd1);
      void'(done_q.pop_front());
    end else begin
      chk("no_done", {31'd0, done}, 32'd0);
    end
    chk("busy", {31'd0, busy}, {31'd0, (cyc >= busy_lo && cyc <= busy_hi)});
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
    en1          = 1'($urandom);
    en2          = 1'($urandom);
    pulse_width1 = 16'($urandom);
    pulse_width2 = 16'($urandom);
    pulse_gap    = 16'($urandom);
  endtask

  // Issue one request in the current cycle; the model decides acceptance from
  // its own notion of when the transmitter is busy
  task automatic do_req(input logic e1, input logic e2, input logic [15:0] w1,
                        input logic [15:0] w2, input logic [15:0] g);
    logic [7:0] bts[$];
    int         r;
    int         sum;
    exp_t       e;
    r            = cyc;
    en1          = e1;
    en2          = e2;
    pulse_width1 = w1;
    pulse_width2 = w2;
    pulse_gap    = g;
    send_req     = 1'b1;
    if (!(r >= busy_lo && r <= busy_hi)) begin
      bts = '{8'h07, {7'd0, e1}, {7'd0, e2}, w1[15:8], w1[7:0], w2[15:8], w2[7:0], g[15:8], g[7:0]};
      if (NB == 10) begin
        sum = 0;
        foreach (bts[i]) sum += int'(bts[i]);
        bts.push_back(8'(sum % 256));
      end
      for (int k = 0; k < NB; k++) begin
        e.data = bts[k];
        e.cyc  = r + 2 + k * STEP;
        exp_q.push_back(e);
      end
      busy_lo = r + 1;
      busy_hi = r + 2 + (NB - 1) * STEP + B + 1;
      done_q.push_back(busy_hi);
    end
    tick();
    send_req = 1'b0;
  endtask

  task automatic model_reset(input int r);
    while (exp_q.size() > 0 && exp_q[$].cyc > r) void'(exp_q.pop_back());
    while (done_q.size() > 0 && done_q[$] > r) void'(done_q.pop_back());
    if (busy_hi > r) busy_hi = r;
    clear_cyc = r + 1;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && done_q.size() == 0 && cyc > busy_hi) && n < bound) begin
      tick();
      n++;
    end
    if (n >= bound) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: still busy after %0d cycles, want idle", bound);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  initial begin
    int r;
    int d;
    sys_rst_n    = 1'b0;
    send_req     = 1'b0;
    en1          = 1'b0;
    en2          = 1'b0;
    pulse_width1 = '0;
    pulse_width2 = '0;
    pulse_gap    = '0;
    model_reset(0);
    repeat (4) tick();
    sys_rst_n = 1'b1;
    repeat (2) tick();

    // Reference frame
    do_req(1'b1, 1'b0, 16'h0108, 16'h0005, 16'h0010);
    wait_idle(2000);
    repeat (3) tick();

    // Second request mid-frame with different inputs is dropped
    r = cyc;
    do_req(1'b0, 1'b1, 16'h1234, 16'h5678, 16'h9abc);
    wait_until(r + 50);
    do_req(1'b1, 1'b1, 16'hffff, 16'hffff, 16'hffff);
    wait_idle(2000);
    repeat (2) tick();

    // Request in FIN ignored, request one cycle later accepted
    do_req(1'b1, 1'b1, 16'h00ff, 16'hff00, 16'h0001);
    d = busy_hi;
    wait_until(d);
    do_req(1'b0, 1'b0, 16'hdead, 16'hbeef, 16'h0bad);
    do_req(1'b0, 1'b1, 16'hcafe, 16'h0102, 16'h0304);
    wait_idle(2000);
    repeat (2) tick();

    // Reset during the WAIT of byte 4 aborts the frame
    r = cyc;
    do_req(1'b1, 1'b0, 16'h0108, 16'h0005, 16'h0010);
    wait_until(r + 2 + 4 * STEP + 20);
    sys_rst_n = 1'b0;
    model_reset(cyc);
    tick();
    chk("reset_pi_data", {24'd0, pi_data}, 32'd0);
    sys_rst_n = 1'b1;
    repeat (3) tick();
    do_req(1'b0, 1'b1, 16'h0a0b, 16'h0c0d, 16'h0e0f);
    wait_idle(2000);

    // Randomised frames with a random extra request somewhere in or after the frame
    for (int f = 0; f < 4; f++) begin
      repeat ($urandom_range(0, 4)) tick();
      r = cyc;
      do_req(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      wait_until(r + $urandom_range(1, NB * STEP + 2));
      do_req(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      wait_idle(3000);
    end

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
